// File: rtl/mash_pkg.sv
// Shared types and constants for the MASH 1-1 sigma-delta modulator.
package mash_pkg;
  localparam int DATA_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Output code is y+1, so y = -1..2 maps onto 0..3.
  localparam logic [1:0] CODE_MIN  = 2'd0;
  localparam logic [1:0] CODE_ZERO = 2'd1;
  localparam logic [1:0] CODE_MAX  = 2'd3;
endpackage

// File: rtl/mash_acc_stage.sv
// First-order accumulator: acc <= acc + din with the carry-out exposed combinationally.
module mash_acc_stage
  import mash_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  step,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] acc_q,
  output logic                  carry
);
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] acc_d;

  assign sum   = {1'b0, acc_q} + {1'b0, din};
  assign carry = sum[DATA_WIDTH];

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/mash11_modulator.sv
// Second-order MASH 1-1 modulator: one sample per OSR clocks in, one 2-bit code per clock out,
// with a one-entry input buffer and a sticky underrun flag.
module mash11_modulator
  import mash_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int OSR        = 16,
  parameter int CNT_WIDTH  = $clog2(OSR)
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic                  clear_underrun,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [1:0]            mod_out,
  output logic                  mod_valid,
  output logic                  underrun
);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OSR - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] x_hold_q, x_hold_d;
  logic [DATA_WIDTH-1:0] smp_buf_q, smp_buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  c2_dly_q, c2_dly_d;
  logic                  underrun_q, underrun_d;
  logic [1:0]            mod_out_q, mod_out_d;
  logic                  mod_valid_q, mod_valid_d;

  logic                  hs, wrap, step, clr, c1, c2;
  logic [DATA_WIDTH-1:0] acc1_q, sum1_lo;
  // The second stage only contributes its carry; its state stays internal.
  logic [DATA_WIDTH-1:0] acc2_unused;

  function automatic logic [1:0] step_code(input logic a, input logic b, input logic prev);
    logic signed [2:0] y;
    y = $signed({2'b00, a}) + $signed({2'b00, b}) - $signed({2'b00, prev});
    return 2'(y + 3'sd1);
  endfunction

  assign step    = (state_q == RUN) && enable;
  assign clr     = (state_q == RUN) && !enable;
  assign sum1_lo = acc1_q + x_hold_q;
  assign hs      = s_axis_data_tvalid && s_axis_data_tready;
  assign wrap    = (cnt_q == CNT_LAST);

  mash_acc_stage #(.DATA_WIDTH(DATA_WIDTH)) u_acc1 (
    .aclk(aclk), .arst(arst), .step(step), .clr(clr),
    .din(x_hold_q), .acc_q(acc1_q), .carry(c1)
  );

  mash_acc_stage #(.DATA_WIDTH(DATA_WIDTH)) u_acc2 (
    .aclk(aclk), .arst(arst), .step(step), .clr(clr),
    .din(sum1_lo), .acc_q(acc2_unused), .carry(c2)
  );

  always_comb begin
    s_axis_data_tready = 1'b0;
    case (state_q)
      PRIME:   s_axis_data_tready = 1'b1;
      RUN:     s_axis_data_tready = !buf_valid_q;
      default: s_axis_data_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    x_hold_d    = x_hold_q;
    smp_buf_d   = smp_buf_q;
    buf_valid_d = buf_valid_q;
    cnt_d       = cnt_q;
    c2_dly_d    = c2_dly_q;
    mod_out_d   = CODE_ZERO;
    mod_valid_d = 1'b0;
    // A boundary-cycle underrun below overrides a simultaneous clear.
    underrun_d  = underrun_q && !clear_underrun;
    case (state_q)
      IDLE: begin
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (hs) begin
          x_hold_d = s_axis_data_tdata;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d     = IDLE;
          buf_valid_d = 1'b0;
          cnt_d       = '0;
          c2_dly_d    = 1'b0;
        end else begin
          mod_out_d   = step_code(c1, c2, c2_dly_q);
          mod_valid_d = 1'b1;
          c2_dly_d    = c2;
          if (wrap) begin
            cnt_d = '0;
            if (buf_valid_q) begin
              x_hold_d    = smp_buf_q;
              buf_valid_d = 1'b0;
            end else if (hs) begin
              x_hold_d = s_axis_data_tdata;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (hs) begin
              smp_buf_d   = s_axis_data_tdata;
              buf_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      x_hold_q    <= '0;
      smp_buf_q   <= '0;
      buf_valid_q <= 1'b0;
      cnt_q       <= '0;
      c2_dly_q    <= 1'b0;
      underrun_q  <= 1'b0;
      mod_out_q   <= CODE_ZERO;
      mod_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_hold_q    <= x_hold_d;
      smp_buf_q   <= smp_buf_d;
      buf_valid_q <= buf_valid_d;
      cnt_q       <= cnt_d;
      c2_dly_q    <= c2_dly_d;
      underrun_q  <= underrun_d;
      mod_out_q   <= mod_out_d;
      mod_valid_q <= mod_valid_d;
    end
  end

  assign mod_out   = mod_out_q;
  assign mod_valid = mod_valid_q;
  assign underrun  = underrun_q;
endmodule

// File: doc/mash11_modulator.md
Name: mash11_modulator

Overview:
- Second-order MASH 1-1 sigma-delta modulator directly downstream of the NCO.
- Consumes 16-bit unsigned samples from the NCO master AXI-Stream (mid-scale 0x8000) at one sample per OSR clocks.
- Runs at full aclk rate and emits a registered 2-bit offset code (0..3) per cycle for the DAC output driver.
- Holds a one-entry input buffer and flags underrun when no sample is ready at a sample boundary.

Parameters:
DATA_WIDTH, 16, input sample and accumulator width
OSR, 16, aclk cycles per input sample (oversampling ratio); legal range >= 2
CNT_WIDTH, $clog2(OSR), width of the phase counter (derived; not overridden)

Ports:
aclk  in  1  clock
arst  in  1  reset, asynchronous, active-high
enable  in  1  run request; low forces IDLE
clear_underrun  in  1  one-cycle pulse that clears underrun
s_axis_data_tdata  in  DATA_WIDTH  unsigned sample
s_axis_data_tvalid  in  1  sample valid
s_axis_data_tready  out  1  buffer can accept
mod_out  out  2  offset code y+1, where y is in {-1,0,1,2}
mod_valid  out  1  mod_out holds a new modulator step this cycle
underrun  out  1  sticky: a sample boundary passed with no sample buffered

Behaviour:
- Reset (async assert, sync release): state=IDLE; mod_out=2'd1; mod_valid=0; underrun=0; tready=0; acc1, acc2, c2_d, x_hold, buf, buf_valid, cnt all 0.
- Reset asserted mid-operation clears everything immediately; no partial step survives.
- States:
  - IDLE: tready=0, mod_valid=0, mod_out=1. Go to PRIME when enable=1.
  - PRIME: tready=1. On handshake, load x_hold=tdata, cnt=0, go to RUN. Go to IDLE if enable=0.
  - RUN: the modulator steps every cycle.
    - mod_valid=1 from the first edge after entering RUN.
    - Go to IDLE if enable=0; acc1, acc2, c2_d, buf_valid and cnt are cleared and underrun is retained.
- Modulator step, all registered, one step per cycle in RUN:
  - sum1 = acc1 + x_hold, computed DATA_WIDTH+1 wide; c1 = sum1[MSB]; acc1 <= sum1[DATA_WIDTH-1:0].
  - sum2 = acc2 + sum1[DATA_WIDTH-1:0]; c2 = sum2[MSB]; acc2 <= low bits of sum2.
  - c2_d <= c2.
  - y = c1 + c2 - c2_d, signed; mod_out <= y + 1.
  - Long-run mean of y = x_hold / 2^DATA_WIDTH.
- Latency: a sample that handshakes at edge k affects mod_out first at edge k+1, visible after that edge.
- Input buffering in RUN:
  - tready = !buf_valid.
  - A handshake loads buf and sets buf_valid.
- Sample boundary: cnt counts 0..OSR-1 and wraps. At the wrap edge:
  - If buf_valid=1: x_hold <= buf and buf_valid clears.
  - If buf_valid=0 and a handshake occurs in the same cycle: x_hold <= tdata directly; no underrun.
  - Otherwise: x_hold is retained and underrun is set.
- underrun clears on clear_underrun. If set and clear occur in the same cycle, set wins.
- Steady state with tvalid held high: exactly one handshake per OSR cycles.

Decomposition:
- Package mash_pkg holds:
  - DATA_WIDTH default;
  - state enum (IDLE, PRIME, RUN);
  - code constants CODE_ZERO=2'd1, CODE_MIN=2'd0, CODE_MAX=2'd3.
- Sub-module mash_acc_stage: one first-order accumulator with carry-out.
  - Ports: aclk, arst, step, clr, din[DATA_WIDTH], acc_q, carry.
  - Instantiated twice; the top level adds c2_d, the output combine logic, the FSM, the counter and the buffer.

Test Plan:
1. Hold x=0x0000 with tvalid high, enable=1 -> after entering RUN, mod_out=1 on every valid cycle and underrun stays 0.
2. Hold x=0x8000, OSR=16 -> c1 alternates 0,1 and c2 pulses once every 4 steps; over 64 valid steps the sum of (mod_out-1) is 32±1.
3. Hold x=0xFFFF -> over 256 valid steps the sum of (mod_out-1) is in [254,256] and every mod_out is in 0..3.
4. Throughput check with tvalid always high, OSR=16 -> handshakes exactly 16 cycles apart in RUN; underrun stays 0.
5. Underrun and recovery:
   - Send one sample, then drop tvalid -> underrun rises at the edge OSR cycles after load and x_hold is unchanged.
   - Pulse clear_underrun -> underrun=0.
   - Pulse set and clear in the same cycle -> underrun=1.
6. Mode control and reset:
   - Deassert enable mid-RUN -> next cycle mod_valid=0, mod_out=1, tready=0.
   - Re-enable -> PRIME with accumulators at 0.
   - Assert arst asynchronously mid-cycle -> outputs are at reset values before the next edge.
